// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath widths and the
// divide-by-zero result.
package alu_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;

    localparam logic [RESULT_W-1:0] DIV_BY_ZERO_RESULT = 16'hFFFF;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_NAND = 4'd8,
        OP_NOR  = 4'd9,
        OP_XNOR = 4'd10,
        OP_SHL  = 4'd11,
        OP_SHR  = 4'd12,
        OP_ROL  = 4'd13,
        OP_CMP  = 4'd14,
        OP_INC  = 4'd15
    } alu_op_e;

endpackage

// File: rtl/alu_modport_core.sv
// Combinational ALU datapath: maps operands and opcode to the next 16-bit
// result. Operands are unsigned and zero-extended; results wrap mod 2^16.
module alu_modport_core
    import alu_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic [3:0]           s,
    output logic [RESULT_W-1:0]  result
);

    alu_op_e             op;
    logic [RESULT_W-1:0] a_ext;
    logic [RESULT_W-1:0] b_ext;
    logic [RESULT_W-1:0] rol_wide;
    logic                b_zero;

    assign op     = alu_op_e'(s);
    assign a_ext  = {8'h00, a};
    assign b_ext  = {8'h00, b};
    assign b_zero = (b == 8'h00);

    // Shifting the doubled operand left puts the rotated byte in the top half.
    assign rol_wide = {a, a} << b[2:0];

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_DIV:  result = b_zero ? DIV_BY_ZERO_RESULT : a_ext / b_ext;
            OP_MOD:  result = b_zero ? a_ext : a_ext % b_ext;
            OP_AND:  result = {8'h00, a & b};
            OP_OR:   result = {8'h00, a | b};
            OP_XOR:  result = {8'h00, a ^ b};
            OP_NAND: result = {8'h00, ~(a & b)};
            OP_NOR:  result = {8'h00, ~(a | b)};
            OP_XNOR: result = {8'h00, ~(a ^ b)};
            OP_SHL:  result = {7'd0, a, 1'b0};
            OP_SHR:  result = {9'd0, a[7:1]};
            OP_ROL:  result = {8'h00, rol_wide[15:8]};
            OP_CMP:  result = {13'd0, (a < b), (a > b), (a == b)};
            OP_INC:  result = a_ext + 16'd1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_modport.sv
// Registered ALU: one rising-edge latency from (a, b, s) to out, cleared by
// a synchronous active-high reset. out is driven only by the register.
module alu_modport
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic [3:0]           s,
    output logic [RESULT_W-1:0]  out
);

    logic [RESULT_W-1:0] next_result;

    alu_modport_core u_core (
        .a      (a),
        .b      (b),
        .s      (s),
        .result (next_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= next_result;
        end
    end

endmodule

// File: tb/tb_alu_modport.sv
// Directed bench for alu_modport: inputs change 2 ns after a falling edge,
// out is sampled at the next falling edge.
module tb_alu_modport;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  s;
    logic [15:0] out;

    int n_cmp;
    int n_err;

    logic [15:0] exp_q[$];

    alu_modport dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .s   (s),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference model, written from the opcode table.
    function automatic logic [15:0] ref_model(input logic [7:0] ra, input logic [7:0] rb,
                                              input logic [3:0] rs);
        int ia;
        int ib;
        int r;
        int v;
        ia = ra;
        ib = rb;
        r  = rb & 7;
        case (rs)
            4'd0:  v = ia + ib;
            4'd1:  v = ia - ib;
            4'd2:  v = ia * ib;
            4'd3:  v = (ib == 0) ? 'hFFFF : ia / ib;
            4'd4:  v = (ib == 0) ? ia : ia % ib;
            4'd5:  v = ia & ib;
            4'd6:  v = ia | ib;
            4'd7:  v = ia ^ ib;
            4'd8:  v = (~(ia & ib)) & 'hFF;
            4'd9:  v = (~(ia | ib)) & 'hFF;
            4'd10: v = (~(ia ^ ib)) & 'hFF;
            4'd11: v = ia * 2;
            4'd12: v = ia / 2;
            4'd13: v = ((ia << r) | (ia >> (8 - r))) & 'hFF;
            4'd14: v = (ia == ib ? 1 : 0) + (ia > ib ? 2 : 0) + (ia < ib ? 4 : 0);
            default: v = ia + 1;
        endcase
        return 16'(v & 'hFFFF);
    endfunction

    // Drive one vector (caller sits at a falling edge), then check at the next falling edge.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vs,
                          input logic [15:0] exp_v, input string name);
        #2;
        a = va;
        b = vb;
        s = vs;
        @(negedge clk);
        n_cmp++;
        if (out !== exp_v) begin
            n_err++;
            $display("FAIL %s: out=%h expected=%h", name, out, exp_v);
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        a   = 8'hFF;
        b   = 8'hFF;
        s   = 4'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_hold_%0d: out=%h expected=0000", i, out);
            end
        end
        #2;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out !== 16'hFE01) begin
            n_err++;
            $display("FAIL reset_release: out=%h expected=fe01", out);
        end
    endtask

    task automatic test_arith();
        run_op(8'd200, 8'd100, 4'd0, 16'd300,   "add");
        run_op(8'd200, 8'd100, 4'd1, 16'd100,   "sub");
        run_op(8'd200, 8'd100, 4'd2, 16'd20000, "mul");
        run_op(8'd200, 8'd100, 4'd3, 16'd2,     "div");
        run_op(8'd200, 8'd100, 4'd4, 16'd0,     "mod");
        run_op(8'd1,   8'd2,   4'd1, 16'hFFFF,  "sub_wrap");
        run_op(8'hFF,  8'hFF,  4'd0, 16'h01FE,  "add_max");
    endtask

    task automatic test_div_zero();
        run_op(8'h37, 8'h00, 4'd3, 16'hFFFF, "div_zero");
        run_op(8'h37, 8'h00, 4'd4, 16'h0037, "mod_zero");
    endtask

    task automatic test_logic_shift();
        run_op(8'hA5, 8'h0F, 4'd5,  16'h0005, "and");
        run_op(8'hA5, 8'h0F, 4'd6,  16'h00AF, "or");
        run_op(8'hA5, 8'h0F, 4'd7,  16'h00AA, "xor");
        run_op(8'hA5, 8'h0F, 4'd8,  16'h00FA, "nand");
        run_op(8'hA5, 8'h0F, 4'd9,  16'h0050, "nor");
        run_op(8'hA5, 8'h0F, 4'd10, 16'h0055, "xnor");
        run_op(8'hA5, 8'h0F, 4'd11, 16'h014A, "shl");
        run_op(8'hA5, 8'h0F, 4'd12, 16'h0052, "shr");
        run_op(8'hA5, 8'h07, 4'd13, 16'h00D2, "rol7");
        run_op(8'hA5, 8'h01, 4'd13, 16'h004B, "rol1");
        run_op(8'hA5, 8'h08, 4'd13, 16'h00A5, "rol0");
    endtask

    task automatic test_cmp_inc();
        run_op(8'd5,  8'd5,  4'd14, 16'h0001, "cmp_eq");
        run_op(8'd9,  8'd3,  4'd14, 16'h0002, "cmp_gt");
        run_op(8'd3,  8'd9,  4'd14, 16'h0004, "cmp_lt");
        run_op(8'hFF, 8'h00, 4'd15, 16'h0100, "inc_wrap");
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            #2;
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            s   = 4'(i);
            rst = (i == 8);
            exp_q.push_back(rst ? 16'h0000 : ref_model(a, b, s));
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (out !== exp_v) begin
                n_err++;
                $display("FAIL b2b_op%0d: out=%h expected=%h (a=%h b=%h rst=%b)",
                         i, out, exp_v, a, b, rst);
            end
        end
        #2;
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        s     = 4'd0;
        @(negedge clk);
        test_reset();
        test_arith();
        test_div_zero();
        test_logic_shift();
        test_cmp_inc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
